// File: rtl/spi_slave_tx.sv
// spi_slave_tx
// Slave-side SPI transmitter. Sends a WIDTH-bit response word on miso, LSB
// first, one bit per sclk period while cs is low. sclk and cs are
// oversampled in the clk domain. Response words arrive from local logic
// through a one-deep holding buffer.
//
// Handshake: a word transfers on a clk edge where tx_valid && tx_ready.
// tx_ready is high only while out of reset and the holding buffer is empty.
// tx_data must stay stable while tx_valid is high and tx_ready is low.
//
// Ports
//   clk       system clock
//   rst       synchronous active-low reset
//   sclk      SPI clock from master (asynchronous, synchronized here)
//   cs        chip select from master, active low (synchronized here)
//   tx_data   response word from local logic
//   tx_valid  tx_data is valid
//   tx_ready  holding buffer empty
//   miso      serial data to the master
//   busy      frame in progress (state SHIFT)
//   done      one-cycle pulse when all WIDTH bits have been sampled
//   underrun  one-cycle pulse when a frame starts with the buffer empty
//   abort     one-cycle pulse when cs rises before the frame completes
module spi_slave_tx #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             miso,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic             abort
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] N_BITS   = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    state_t state, next_state;

    // Synchronizers: stages 1-2 resynchronize, stage 3 is the edge register.
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    // Tracks which cs stages hold real pin samples since reset. The cs chain
    // resets to 1, and that reset value must not be mistaken for cs high,
    // otherwise a cs held low through reset would arm the block.
    logic [1:0] cs_real;
    logic       armed;

    logic             hold_valid;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;

    logic sclk_rise, sclk_fall, cs_fall, cs_high, handshake;
    logic start_frame, do_rise, last_rise, do_shift, do_abort;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
            cs_real   <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs};
            cs_real   <= {cs_real[0], 1'b1};
            if (cs_real[1] && cs_sync[1])
                armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_high   = cs_sync[1];
    assign tx_ready  = rst & ~hold_valid;
    assign handshake = tx_valid & tx_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (armed && cs_fall) next_state = SHIFT;
            SHIFT: begin
                if (cs_high)                               next_state = IDLE;
                else if (sclk_rise && bitcnt == LAST_BIT)  next_state = WAIT_CS;
            end
            WAIT_CS: if (cs_high) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / control decode. cs high wins over sclk edges in SHIFT.
    always_comb begin
        start_frame = (state == IDLE) && armed && cs_fall;
        do_abort    = (state == SHIFT) && cs_high;
        do_rise     = (state == SHIFT) && !cs_high && sclk_rise;
        last_rise   = do_rise && (bitcnt == LAST_BIT);
        // Shift only on falls after the first rise and before the last one.
        do_shift    = (state == SHIFT) && !cs_high && sclk_fall &&
                      (bitcnt != '0) && (bitcnt < N_BITS);
        busy        = (state == SHIFT);
    end

    // Datapath and registered pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            miso       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            abort      <= 1'b0;
        end else begin
            done     <= last_rise;
            underrun <= start_frame && !hold_valid;
            abort    <= do_abort;

            // A handshake only happens with the buffer empty, so it can never
            // collide with the buffer being consumed below.
            if (handshake) begin
                hold       <= tx_data;
                hold_valid <= 1'b1;
            end

            if (start_frame) begin
                bitcnt <= '0;
                if (hold_valid) begin
                    shreg      <= hold;
                    miso       <= hold[0];
                    hold_valid <= 1'b0;
                end else begin
                    shreg <= '0;
                    miso  <= 1'b0;
                end
            end

            if (do_rise) begin
                bitcnt <= bitcnt + CW'(1);
                if (last_rise) miso <= 1'b0;
            end

            if (do_shift) begin
                shreg <= shreg >> 1;
                miso  <= shreg[1];
            end

            if (do_abort) miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Testbench for spi_slave_tx: a task-driven SPI master plus local-side
// drivers; a monitor pops expected words from exp_q on every done pulse.
module tb_spi_slave_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic [11:0] tx_data = 12'h000;
    logic        tx_valid = 1'b0;
    logic        tx_ready, miso, busy, done, underrun, abort;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int underrun_cnt = 0;
    int abort_cnt = 0;
    logic        quiet = 1'b0;
    logic        quiet_bad = 1'b0;
    logic [11:0] rx_word = 12'h000;
    logic [11:0] exp_q[$];

    spi_slave_tx #(.WIDTH(12)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .miso(miso), .busy(busy), .done(done),
        .underrun(underrun), .abort(abort)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 3000 && !tx_ready; i++) wait_clk(1);
        if (!tx_ready) check(name, 32'(tx_ready), 32'd1);
    endtask

    // Local-side driver: present one word until it is accepted.
    task automatic send_word(input logic [11:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_ready("send_timeout");
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    // SPI master: half-period 11 clk cycles, samples miso at each sclk rise.
    // Optionally offers load_w in the cycle the DUT detects the cs fall.
    task automatic master_frame(input int nrise, input logic load_en, input logic [11:0] load_w);
        rx_word = 12'h000;
        cs = 1'b0;
        if (load_en) begin
            wait_clk(2);
            tx_data  = load_w;
            tx_valid = 1'b1;
            wait_clk(1);
            tx_valid = 1'b0;
            wait_clk(8);
        end else begin
            wait_clk(11);
        end
        for (int k = 0; k < nrise; k++) begin
            sclk = 1'b1;
            if (k < 12) rx_word[k] = miso;
            wait_clk(11);
            sclk = 1'b0;
            wait_clk(11);
        end
        cs = 1'b1;
        wait_clk(8);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("done_with_empty_queue", 32'd1, 32'd0);
            end else begin
                check("frame_word", 32'(rx_word), 32'(exp_q.pop_front()));
            end
        end
        if (underrun) underrun_cnt++;
        if (abort) abort_cnt++;
        if (quiet && (busy || miso || done || underrun || abort)) quiet_bad = 1'b1;
    end

    initial begin
        // Reset
        wait_clk(3);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_outputs", {27'd0, miso, busy, done, underrun, abort}, 32'd0);
        rst = 1'b1;
        wait_clk(1);
        check("release_tx_ready", 32'(tx_ready), 32'd1);
        wait_clk(5);

        // Basic frame
        send_word(12'hA5C);
        check("basic_ready_drop", 32'(tx_ready), 32'd0);
        exp_q.push_back(12'hA5C);
        master_frame(12, 1'b0, 12'h000);
        check("basic_ready_after", 32'(tx_ready), 32'd1);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_no_underrun", 32'(underrun_cnt), 32'd0);

        // Underrun, with a word loaded in the cs-fall cycle
        exp_q.push_back(12'h000);
        master_frame(12, 1'b1, 12'h0F1);
        check("underrun_cnt", 32'(underrun_cnt), 32'd1);
        check("underrun_hold_full", 32'(tx_ready), 32'd0);
        exp_q.push_back(12'h0F1);
        master_frame(12, 1'b0, 12'h000);
        check("underrun_cnt_after", 32'(underrun_cnt), 32'd1);
        check("underrun_done_cnt", 32'(done_cnt), 32'd3);

        // Back-to-back with tx_valid held
        fork
            begin
                tx_data  = 12'h001;
                tx_valid = 1'b1;
                wait_ready("b2b_timeout1");
                wait_clk(1);
                tx_data = 12'hFFF;
                check("b2b_ready_drop1", 32'(tx_ready), 32'd0);
                wait_ready("b2b_timeout2");
                wait_clk(1);
                tx_valid = 1'b0;
                check("b2b_ready_drop2", 32'(tx_ready), 32'd0);
            end
            begin
                wait_clk(2);
                exp_q.push_back(12'h001);
                master_frame(12, 1'b0, 12'h000);
                exp_q.push_back(12'hFFF);
                master_frame(12, 1'b0, 12'h000);
            end
        join
        check("b2b_done_cnt", 32'(done_cnt), 32'd5);

        // Abort after 5 rises; a word buffered during the frame goes next
        send_word(12'h3C3);
        fork
            master_frame(5, 1'b0, 12'h000);
            begin
                wait_clk(40);
                send_word(12'h5A6);
            end
        join
        check("abort_cnt", 32'(abort_cnt), 32'd1);
        check("abort_no_done", 32'(done_cnt), 32'd5);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.push_back(12'h5A6);
        master_frame(12, 1'b0, 12'h000);
        check("abort_next_done", 32'(done_cnt), 32'd6);

        // Reset mid-frame during bit 6
        send_word(12'h777);
        fork
            master_frame(12, 1'b0, 12'h000);
            begin
                wait_clk(138);
                rst = 1'b0;
                wait_clk(1);
                check("midrst_outputs", {26'd0, tx_ready, miso, busy, done, underrun, abort}, 32'd0);
                wait_clk(1);
                rst = 1'b1;
                quiet = 1'b1;
            end
        join
        quiet = 1'b0;
        check("midrst_quiet", 32'(quiet_bad), 32'd0);
        check("midrst_no_done", 32'(done_cnt), 32'd6);
        check("midrst_no_underrun", 32'(underrun_cnt), 32'd1);
        send_word(12'hABC);
        exp_q.push_back(12'hABC);
        master_frame(12, 1'b0, 12'h000);
        check("midrst_recover_done", 32'(done_cnt), 32'd7);

        // Reset release with cs low
        cs  = 1'b0;
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_clk(11);
            sclk = 1'b1;
            wait_clk(11);
            sclk = 1'b0;
        end
        wait_clk(5);
        quiet = 1'b0;
        check("release_cs_low_quiet", 32'(quiet_bad), 32'd0);
        check("release_no_underrun", 32'(underrun_cnt), 32'd1);
        cs = 1'b1;
        wait_clk(8);
        send_word(12'h123);
        exp_q.push_back(12'h123);
        master_frame(12, 1'b0, 12'h000);

        // Final accounting
        wait_clk(5);
        check("final_done_cnt", 32'(done_cnt), 32'd8);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_abort_cnt", 32'(abort_cnt), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
